pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the five-stage LoongArch core (IF/ID/EX/MEM/WB).
- Owns the per-stage valid bits and the per-stage destination scoreboard.
- Generates PC/latch enables, load-use and RAW stalls, branch flush and operand-forwarding selects.
- Instantiated beside the datapath; replaces the free-running pipeline registers with qualified enables.

---
 rtl/pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline valid/scoreboard, stall, flush and forwarding control
//
// Purpose: owns the ID/EX/MEM/WB valid bits and the EX/MEM/WB destination
// scoreboard, and derives latch enables, load-use/RAW stalls, the qualified
// branch redirect and the operand-forwarding selects for the datapath.
//
// Configuration macro: PIPE_FWD_EN
//   defined   - EX/MEM results are forwarded; only load-use hazards stall.
//   undefined - no forwarding; any RAW match in EX/MEM/WB stalls and the
//               forwarding selects are tied to 0.
//
// Ports:
//   clk, resetn          core clock, asynchronous active-low reset
//   ext_freeze           external stall, freezes every stage
//   id_rj/id_r2          ID source register numbers, id_use_rj/id_use_r2 qualify them
//   id_gr_we/id_dest     ID instruction writes id_dest
//   id_is_load           ID instruction is a load
//   id_br_taken          raw branch-taken from ID
//   pc_we/ifid_we/idex_we  pipeline latch enables
//   br_redirect          qualified redirect to the branch target
//   id/ex/mem/wb_valid   per-stage live-instruction flags
//   fwd_sel1/fwd_sel2    0 regfile, 1 EX, 2 MEM, 3 WB
//   stall_cnt            saturating count of hazard-stall cycles
module pipe_hazard_ctrl #(
  parameter int RF_AW       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ext_freeze,
  input  logic [RF_AW-1:0]       id_rj,
  input  logic [RF_AW-1:0]       id_r2,
  input  logic                   id_use_rj,
  input  logic                   id_use_r2,
  input  logic                   id_gr_we,
  input  logic [RF_AW-1:0]       id_dest,
  input  logic                   id_is_load,
  input  logic                   id_br_taken,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_we,
  output logic                   br_redirect,
  output logic                   id_valid,
  output logic                   ex_valid,
  output logic                   mem_valid,
  output logic                   wb_valid,
  output logic [1:0]             fwd_sel1,
  output logic [1:0]             fwd_sel2,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   id_valid_q, id_valid_d;
  logic                   ex_valid_q, ex_valid_d;
  logic                   mem_valid_q, mem_valid_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [RF_AW-1:0]       ex_dest_q, ex_dest_d;
  logic [RF_AW-1:0]       mem_dest_q, mem_dest_d;
  logic [RF_AW-1:0]       wb_dest_q, wb_dest_d;
  logic                   ex_we_q, ex_we_d;
  logic                   mem_we_q, mem_we_d;
  logic                   wb_we_q, wb_we_d;
  // Load flag is only tracked in EX and MEM: a load in WB is always forwardable.
  logic                   ex_load_q, ex_load_d;
  logic                   mem_load_q, mem_load_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic hazard_stall;

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic src_hit(input logic v, input logic we,
                                   input logic [RF_AW-1:0] dest,
                                   input logic [RF_AW-1:0] src,
                                   input logic use_src);
    return v & we & use_src & (src != '0) & (dest == src);
  endfunction

  assign ex_hit1  = src_hit(ex_valid_q,  ex_we_q,  ex_dest_q,  id_rj, id_use_rj);
  assign ex_hit2  = src_hit(ex_valid_q,  ex_we_q,  ex_dest_q,  id_r2, id_use_r2);
  assign mem_hit1 = src_hit(mem_valid_q, mem_we_q, mem_dest_q, id_rj, id_use_rj);
  assign mem_hit2 = src_hit(mem_valid_q, mem_we_q, mem_dest_q, id_r2, id_use_r2);
  assign wb_hit1  = src_hit(wb_valid_q,  wb_we_q,  wb_dest_q,  id_rj, id_use_rj);
  assign wb_hit2  = src_hit(wb_valid_q,  wb_we_q,  wb_dest_q,  id_r2, id_use_r2);

`ifdef PIPE_FWD_EN
  assign hazard_stall = id_valid_q &
                        ((ex_load_q  & (ex_hit1  | ex_hit2)) |
                         (mem_load_q & (mem_hit1 | mem_hit2)));

  // Nearest producer wins; a load match in EX/MEM only occurs while stalled,
  // where the select is don't-care.
  always_comb begin
    fwd_sel1 = 2'd0;
    if (ex_hit1 & ~ex_load_q)        fwd_sel1 = 2'd1;
    else if (mem_hit1 & ~mem_load_q) fwd_sel1 = 2'd2;
    else if (wb_hit1)                fwd_sel1 = 2'd3;
    fwd_sel2 = 2'd0;
    if (ex_hit2 & ~ex_load_q)        fwd_sel2 = 2'd1;
    else if (mem_hit2 & ~mem_load_q) fwd_sel2 = 2'd2;
    else if (wb_hit2)                fwd_sel2 = 2'd3;
  end
`else
  logic unused_load;

  // Without forwarding the consumer waits until the producer leaves WB.
  assign hazard_stall = id_valid_q &
                        (ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2 | wb_hit1 | wb_hit2);
  assign fwd_sel1     = 2'd0;
  assign fwd_sel2     = 2'd0;
  assign unused_load  = ex_load_q ^ mem_load_q;
`endif

  assign br_redirect = id_valid_q & id_br_taken & ~hazard_stall & ~ext_freeze;

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    id_valid_d  = id_valid_q;
    ex_valid_d  = ex_valid_q;
    mem_valid_d = mem_valid_q;
    wb_valid_d  = wb_valid_q;
    ex_dest_d   = ex_dest_q;
    mem_dest_d  = mem_dest_q;
    wb_dest_d   = wb_dest_q;
    ex_we_d     = ex_we_q;
    mem_we_d    = mem_we_q;
    wb_we_d     = wb_we_q;
    ex_load_d   = ex_load_q;
    mem_load_d  = mem_load_q;
    stall_cnt_d = stall_cnt_q;
    if (!ext_freeze) begin
      pc_we       = ~hazard_stall;
      ifid_we     = ~hazard_stall;
      idex_we     = 1'b1;
      // Stall keeps ID live (id_valid_q is 1); redirect kills the fall-through fetch.
      id_valid_d  = ~br_redirect;
      ex_valid_d  = id_valid_q & ~hazard_stall;
      ex_dest_d   = id_dest;
      ex_we_d     = id_gr_we;
      ex_load_d   = id_is_load;
      mem_valid_d = ex_valid_q;
      mem_dest_d  = ex_dest_q;
      mem_we_d    = ex_we_q;
      mem_load_d  = ex_load_q;
      wb_valid_d  = mem_valid_q;
      wb_dest_d   = mem_dest_q;
      wb_we_d     = mem_we_q;
      if (hazard_stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      ex_dest_q   <= '0;
      mem_dest_q  <= '0;
      wb_dest_q   <= '0;
      ex_we_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_load_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      ex_dest_q   <= ex_dest_d;
      mem_dest_q  <= mem_dest_d;
      wb_dest_q   <= wb_dest_d;
      ex_we_q     <= ex_we_d;
      mem_we_q    <= mem_we_d;
      wb_we_q     <= wb_we_d;
      ex_load_q   <= ex_load_d;
      mem_load_q  <= mem_load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          ext_freeze;
  logic [AW-1:0] id_rj, id_r2, id_dest;
  logic          id_use_rj, id_use_r2, id_gr_we, id_is_load, id_br_taken;
  logic          pc_we, ifid_we, idex_we, br_redirect;
  logic          id_valid, ex_valid, mem_valid, wb_valid;
  logic [1:0]    fwd_sel1, fwd_sel2;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int n;

  pipe_hazard_ctrl #(.RF_AW(AW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .ext_freeze(ext_freeze),
    .id_rj(id_rj), .id_r2(id_r2), .id_use_rj(id_use_rj), .id_use_r2(id_use_r2),
    .id_gr_we(id_gr_we), .id_dest(id_dest), .id_is_load(id_is_load),
    .id_br_taken(id_br_taken), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .br_redirect(br_redirect), .id_valid(id_valid), .ex_valid(ex_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          frz;
    logic [AW-1:0] rj;
    logic [AW-1:0] r2;
    logic          urj;
    logic          ur2;
    logic          we;
    logic [AW-1:0] dest;
    logic          ld;
    logic          br;
    logic [2:0]    en;
    logic          redir;
    logic [3:0]    vld;
    logic [1:0]    s1;
    logic [1:0]    s2;
  } vec_t;

  vec_t tbl [12];

  // Reference model: stage 0 = ID, 1 = EX, 2 = MEM, 3 = WB.
  logic          m_v [4];
  logic [AW-1:0] m_d [4];
  logic          m_w [4];
  logic          m_l [4];
  int            m_cnt;
  int            near1, near2;
  bit            blk, any, e_stall, e_redir;
  logic [2:0]    e_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_in();
    ext_freeze = 1'b0; id_rj = '0; id_r2 = '0; id_use_rj = 1'b0; id_use_r2 = 1'b0;
    id_gr_we = 1'b0; id_dest = '0; id_is_load = 1'b0; id_br_taken = 1'b0;
  endtask

  task automatic set_id(input logic [AW-1:0] rj, input logic [AW-1:0] r2,
                        input logic urj, input logic ur2, input logic we,
                        input logic [AW-1:0] dest, input logic ld, input logic br);
    id_rj = rj; id_r2 = r2; id_use_rj = urj; id_use_r2 = ur2;
    id_gr_we = we; id_dest = dest; id_is_load = ld; id_br_taken = br;
  endtask

  // Leaves the bench at posedge+1 of cycle 0, reset just released.
  task automatic reset_dut();
    nop_in();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Counts cycles (holding ID inputs) while the hazard stall keeps pc_we low.
  task automatic count_stalls();
    n = 0;
    while (!pc_we && n < 8) begin
      n++;
      tick();
      #4;
    end
  endtask

  function automatic bit mt(input int s, input logic [AW-1:0] x, input logic u);
    return m_v[s] && m_w[s] && (m_d[s] == x) && (x != '0) && u;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            frz  rj     r2     urj  ur2  we   dest   ld   br    en      rd   vld      s1    s2
    tbl[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 3'b111, 1'b0, 4'b0000, 2'd0, 2'd0};
    tbl[1]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1000, 2'd0, 2'd0};
    tbl[2]  = '{1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1100, 2'd0, 2'd0};
    tbl[3]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1110, 2'd0, 2'd0};
    tbl[4]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1111, 2'd0, 2'd0};
    tbl[5]  = '{1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 3'b111, 1'b1, 4'b1111, 2'd0, 2'd0};
    tbl[6]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 3'b111, 1'b0, 4'b0111, 2'd0, 2'd0};
    tbl[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1011, 2'd0, 2'd0};
    tbl[8]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 3'b000, 1'b0, 4'b1101, 2'd0, 2'd0};
    tbl[9]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b1101, 2'd0, 2'd0};
    tbl[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1101, 2'd0, 2'd0};
    tbl[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b111, 1'b0, 4'b1110, 2'd0, 2'd0};

    nop_in();
    resetn = 1'b0;
    #3;
    check("reset_valids", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);

    // Table: free run, r0 write/read, taken branch with killed slot, freeze.
    reset_dut();
    for (int k = 0; k < 12; k++) begin
      ext_freeze = tbl[k].frz;
      set_id(tbl[k].rj, tbl[k].r2, tbl[k].urj, tbl[k].ur2, tbl[k].we,
             tbl[k].dest, tbl[k].ld, tbl[k].br);
      #4;
      check($sformatf("tbl%0d_en", k), 32'({pc_we, ifid_we, idex_we}), 32'(tbl[k].en));
      check($sformatf("tbl%0d_redir", k), 32'(br_redirect), 32'(tbl[k].redir));
      check($sformatf("tbl%0d_vld", k), 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'(tbl[k].vld));
      check($sformatf("tbl%0d_sel", k), 32'({fwd_sel1, fwd_sel2}), 32'({tbl[k].s1, tbl[k].s2}));
      check($sformatf("tbl%0d_cnt", k), 32'(stall_cnt), 32'd0);
      tick();
    end

    // ALU producer followed by a consumer after 0, 1 and 2 gaps.
    for (int g = 0; g < 3; g++) begin
      reset_dut();
      tick();
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < g; i++) begin
        nop_in();
        tick();
      end
      set_id(5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      #4;
      check($sformatf("raw_gap%0d_sel1", g), 32'(fwd_sel1), FWD ? 32'(g + 1) : 32'd0);
      check($sformatf("raw_gap%0d_sel2", g), 32'(fwd_sel2), FWD ? 32'(g + 1) : 32'd0);
      count_stalls();
      check($sformatf("raw_gap%0d_stalls", g), 32'(n), FWD ? 32'd0 : 32'(3 - g));
    end

    // Load-use.
    reset_dut();
    tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    #4;
    count_stalls();
    check("ld_use_stalls", 32'(n), FWD ? 32'd2 : 32'd3);
    check("ld_use_cnt", 32'(stall_cnt), FWD ? 32'd2 : 32'd3);
    check("ld_use_bubble", 32'(ex_valid), 32'd0);
    check("ld_use_sel1", 32'(fwd_sel1), FWD ? 32'd3 : 32'd0);
    check("ld_use_sel2", 32'(fwd_sel2), 32'd0);

    // Freeze held for 3 cycles over the first load-use stall cycle.
    reset_dut();
    tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    ext_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      check($sformatf("frz%0d_en", i), 32'({pc_we, ifid_we, idex_we, br_redirect}), 32'd0);
      check($sformatf("frz%0d_vld", i), 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'b1100);
      check($sformatf("frz%0d_cnt_sel", i), 32'({stall_cnt, fwd_sel1}), 32'd0);
      tick();
    end
    ext_freeze = 1'b0;
    #4;
    count_stalls();
    check("frz_stalls", 32'(n), FWD ? 32'd2 : 32'd3);
    check("frz_cnt", 32'(stall_cnt), FWD ? 32'd2 : 32'd3);

    // Taken branch whose rj is produced by a load one ahead.
    reset_dut();
    tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #4;
    n = 0;
    while (!br_redirect && n < 8) begin
      n++;
      tick();
      #4;
    end
    check("br_ld_delay", 32'(n), FWD ? 32'd2 : 32'd3);
    tick();
    nop_in();
    #4;
    check("br_ld_killed", 32'(id_valid), 32'd0);
    tick();
    #4;
    check("br_ld_target", 32'(id_valid), 32'd1);

    // Asynchronous reset during a stall.
    reset_dut();
    tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    #4;
    check("rst_mid_pre_cnt", 32'(stall_cnt), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_mid_valids", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'd0);
    check("rst_mid_cnt", 32'(stall_cnt), 32'd0);

    // Randomized run against the stage-array model.
    reset_dut();
    for (int s = 0; s < 4; s++) begin
      m_v[s] = 1'b0; m_d[s] = '0; m_w[s] = 1'b0; m_l[s] = 1'b0;
    end
    m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ext_freeze  = ($urandom_range(0, 9) == 0);
      id_rj       = AW'($urandom_range(0, 3));
      id_r2       = AW'($urandom_range(0, 3));
      id_use_rj   = ($urandom_range(0, 1) == 1);
      id_use_r2   = ($urandom_range(0, 1) == 1);
      id_gr_we    = ($urandom_range(0, 9) < 7);
      id_dest     = AW'($urandom_range(0, 3));
      id_is_load  = ($urandom_range(0, 9) < 3);
      id_br_taken = ($urandom_range(0, 9) < 2);

      near1 = 0; near2 = 0; blk = 1'b0; any = 1'b0;
      for (int s = 1; s < 4; s++) begin
        if (mt(s, id_rj, id_use_rj)) begin
          any = 1'b1;
          if (near1 == 0) near1 = s;
          if (m_l[s] && s < 3) blk = 1'b1;
        end
        if (mt(s, id_r2, id_use_r2)) begin
          any = 1'b1;
          if (near2 == 0) near2 = s;
          if (m_l[s] && s < 3) blk = 1'b1;
        end
      end
      e_stall = m_v[0] && (FWD ? blk : any);
      e_redir = m_v[0] && id_br_taken && !e_stall && !ext_freeze;
      e_en    = ext_freeze ? 3'b000 : (e_stall ? 3'b001 : 3'b111);
      #4;
      check($sformatf("rnd%0d_ctl", cyc),
            32'({pc_we, ifid_we, idex_we, br_redirect, id_valid, ex_valid, mem_valid, wb_valid}),
            32'({e_en, e_redir, m_v[0], m_v[1], m_v[2], m_v[3]}));
      check($sformatf("rnd%0d_cnt", cyc), 32'(stall_cnt), 32'(m_cnt));
      if (!e_stall || !FWD) begin
        check($sformatf("rnd%0d_sel", cyc), 32'({fwd_sel1, fwd_sel2}),
              FWD ? 32'(near1 * 4 + near2) : 32'd0);
      end
      if (!ext_freeze) begin
        if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        for (int s = 3; s > 1; s--) begin
          m_v[s] = m_v[s-1]; m_d[s] = m_d[s-1]; m_w[s] = m_w[s-1]; m_l[s] = m_l[s-1];
        end
        m_v[1] = m_v[0] && !e_stall;
        m_d[1] = id_dest; m_w[1] = id_gr_we; m_l[1] = id_is_load;
        m_v[0] = !e_redir;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
